// File: rtl/multi_cycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// The controller sits on the slave side; the datapath (or a bench) on master.
interface multi_cycle_ctrl_if;
  logic [6:0]  opcode_i;
  logic        zero_i;
  logic        mem_ready_i;

  logic        pc_write_o;
  logic        ir_write_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        reg_write_o;
  logic        mem_to_reg_o;
  logic        pc_src_o;
  logic        alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [1:0]  ALUOp_o;
  logic [2:0]  state_o;
  logic        instr_done_o;
  logic        illegal_o;
  logic        mem_err_o;
  logic [15:0] instr_cnt_o;

  modport master (
    output opcode_i, zero_i, mem_ready_i,
    input  pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o,
           mem_to_reg_o, pc_src_o, alu_src_a_o, alu_src_b_o, ALUOp_o,
           state_o, instr_done_o, illegal_o, mem_err_o, instr_cnt_o
  );

  modport slave (
    input  opcode_i, zero_i, mem_ready_i,
    output pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o,
           mem_to_reg_o, pc_src_o, alu_src_a_o, alu_src_b_o, ALUOp_o,
           state_o, instr_done_o, illegal_o, mem_err_o, instr_cnt_o
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RISC-V style main controller with memory wait timeout and
// retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction, PC+4; waits for mem_ready_i
// DECODE | classify opcode, precompute branch target
// EXEC   | ALU operation / branch resolve
// MEM    | data load or store; waits for mem_ready_i
// WB     | register file write
module multi_cycle_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  multi_cycle_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_I    = 3'd2,
    CLS_LD   = 3'd3,
    CLS_SD   = 3'd4,
    CLS_BEQ  = 3'd5
  } cls_t;

  state_t      r_state;
  state_t      w_state_nxt;
  cls_t        r_cls;
  cls_t        w_cls_dec;
  logic [3:0]  r_wait;
  logic [3:0]  w_wait_nxt;
  logic [15:0] r_instr_cnt;
  logic        w_waiting;
  logic        w_timeout;
  logic        w_done;
  logic        w_illegal;
  logic        w_mem_err;

  // Opcode class decode; anything unrecognised is illegal (CLS_NONE).
  always_comb begin
    w_cls_dec = CLS_NONE;
    case (bus.opcode_i)
      7'b0110011: w_cls_dec = CLS_R;
      7'b0010011: w_cls_dec = CLS_I;
      7'b0000011: w_cls_dec = CLS_LD;
      7'b0100011: w_cls_dec = CLS_SD;
      7'b1100011: w_cls_dec = CLS_BEQ;
      default:    w_cls_dec = CLS_NONE;
    endcase
  end

  assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !bus.mem_ready_i;
  // mem_ready_i wins over timeout because w_waiting already requires it low.
  assign w_timeout = w_waiting && (r_wait == 4'(WAIT_MAX));

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt      = ST_FETCH;
    w_done           = 1'b0;
    w_illegal        = 1'b0;
    w_mem_err        = 1'b0;
    bus.pc_write_o   = 1'b0;
    bus.ir_write_o   = 1'b0;
    bus.mem_read_o   = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.reg_write_o  = 1'b0;
    bus.mem_to_reg_o = 1'b0;
    bus.pc_src_o     = 1'b0;
    bus.alu_src_a_o  = 1'b0;
    bus.alu_src_b_o  = 2'b00;
    bus.ALUOp_o      = 2'b00;
    case (r_state)
      ST_FETCH: begin
        // An aborted access drops its strobe in the timeout cycle.
        bus.mem_read_o  = !w_timeout;
        bus.alu_src_b_o = 2'b01;
        if (bus.mem_ready_i) begin
          bus.ir_write_o = 1'b1;
          bus.pc_write_o = 1'b1;
          w_state_nxt    = ST_DECODE;
        end else begin
          w_mem_err   = w_timeout;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DECODE: begin
        bus.alu_src_b_o = 2'b10;
        if (w_cls_dec == CLS_NONE) begin
          w_illegal   = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        bus.alu_src_a_o = 1'b1;
        case (r_cls)
          CLS_R: begin
            bus.ALUOp_o = 2'b10;
            w_state_nxt = ST_WB;
          end
          CLS_I: begin
            bus.alu_src_b_o = 2'b10;
            bus.ALUOp_o     = 2'b11;
            w_state_nxt     = ST_WB;
          end
          CLS_LD, CLS_SD: begin
            bus.alu_src_b_o = 2'b10;
            w_state_nxt     = ST_MEM;
          end
          CLS_BEQ: begin
            bus.ALUOp_o    = 2'b01;
            bus.pc_src_o   = 1'b1;
            bus.pc_write_o = bus.zero_i;
            w_done         = 1'b1;
            w_state_nxt    = ST_FETCH;
          end
          default: w_state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        bus.mem_read_o  = (r_cls == CLS_LD) && !w_timeout;
        bus.mem_write_o = (r_cls == CLS_SD) && !w_timeout;
        if ((r_cls != CLS_LD) && (r_cls != CLS_SD)) begin
          w_state_nxt = ST_FETCH;
        end else if (bus.mem_ready_i) begin
          w_done      = (r_cls == CLS_SD);
          w_state_nxt = (r_cls == CLS_LD) ? ST_WB : ST_FETCH;
        end else if (w_timeout) begin
          w_mem_err   = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_MEM;
        end
      end
      ST_WB: begin
        bus.reg_write_o  = 1'b1;
        bus.mem_to_reg_o = (r_cls == CLS_LD);
        w_done           = 1'b1;
        w_state_nxt      = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Wait counter restarts on every state change (covers entry to FETCH/MEM)
  // and after a timeout, otherwise counts stalled cycles.
  always_comb begin
    w_wait_nxt = r_wait;
    if ((w_state_nxt != r_state) || w_timeout) begin
      w_wait_nxt = 4'd0;
    end else if (w_waiting) begin
      w_wait_nxt = r_wait + 4'd1;
    end
  end

  // State, latched class, wait counter and retired count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_FETCH;
      r_cls       <= CLS_NONE;
      r_wait      <= 4'd0;
      r_instr_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (r_state == ST_DECODE) begin
        r_cls <= w_cls_dec;
      end
      if (w_done) begin
        r_instr_cnt <= r_instr_cnt + 16'd1;
      end
    end
  end

  // Reset in the same cycle suppresses any status pulse.
  assign bus.instr_done_o = w_done    && !rst_i;
  assign bus.illegal_o    = w_illegal && !rst_i;
  assign bus.mem_err_o    = w_mem_err && !rst_i;
  assign bus.state_o      = r_state;
  assign bus.instr_cnt_o  = r_instr_cnt;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed instruction scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model.
module tb_multi_cycle_ctrl;
  localparam int WAIT_MAX = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // class codes: 0 illegal, 1 R, 2 I, 3 LD, 4 SD, 5 BEQ
  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 1;
      7'b0010011: return 2;
      7'b0000011: return 3;
      7'b0100011: return 4;
      7'b1100011: return 5;
      default:    return 0;
    endcase
  endfunction

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Per-class EXEC behaviour straight from the opcode-class rules.
  int aluop_tbl [6] = '{0, 2, 3, 0, 0, 1};
  int bsel_tbl  [6] = '{0, 0, 2, 2, 2, 0};
  int after_exec[6] = '{0, 4, 4, 3, 3, 0};

  // Behavioural model state
  int          m_st = 0;
  int          m_cls = 0;
  int          m_wait = 0;
  logic [15:0] m_cnt = 16'd0;
  bit          m_valid = 1'b0;
  int          load_seq = 0;
  int          load_seen = 0;

  int e_mr, e_mw, e_irw, e_pcw, e_rw, e_m2r, e_pcs, e_asa, e_bsel, e_aop;
  int e_done, e_ill, e_err, nx;
  bit to, rdy;

  // Compare DUT against model each cycle, then advance the model.
  always @(negedge clk) begin
    if (load_seq != load_seen) begin
      m_cnt     = 16'hFFFF;
      load_seen = load_seq;
    end
    rdy = bus.mem_ready_i;
    to  = ((m_st == 0) || (m_st == 3)) && !rdy && (m_wait == WAIT_MAX);
    e_mr = 0; e_mw = 0; e_irw = 0; e_pcw = 0; e_rw = 0; e_m2r = 0; e_pcs = 0;
    e_asa = 0; e_bsel = 0; e_aop = 0; e_done = 0; e_ill = 0; e_err = 0; nx = 0;
    case (m_st)
      0: begin
        e_mr = !to; e_bsel = 1; e_err = to;
        if (rdy) begin e_irw = 1; e_pcw = 1; nx = 1; end
        else nx = 0;
      end
      1: begin
        e_bsel = 2;
        if (cls_of(bus.opcode_i) == 0) begin e_ill = 1; nx = 0; end
        else nx = 2;
      end
      2: begin
        e_asa = 1; e_bsel = bsel_tbl[m_cls]; e_aop = aluop_tbl[m_cls];
        nx = after_exec[m_cls];
        if (m_cls == 5) begin e_pcs = 1; e_pcw = bus.zero_i; e_done = 1; end
      end
      3: begin
        e_mr = (m_cls == 3) && !to;
        e_mw = (m_cls == 4) && !to;
        if (rdy) begin nx = (m_cls == 3) ? 4 : 0; e_done = (m_cls == 4); end
        else if (to) begin e_err = 1; nx = 0; end
        else nx = 3;
      end
      default: begin
        e_rw = 1; e_m2r = (m_cls == 3); e_done = 1; nx = 0;
      end
    endcase
    if (rst) begin e_done = 0; e_ill = 0; e_err = 0; end

    if (m_valid) begin
      chk("state_o",      bus.state_o,      m_st);
      chk("mem_read_o",   bus.mem_read_o,   e_mr);
      chk("mem_write_o",  bus.mem_write_o,  e_mw);
      chk("ir_write_o",   bus.ir_write_o,   e_irw);
      chk("pc_write_o",   bus.pc_write_o,   e_pcw);
      chk("reg_write_o",  bus.reg_write_o,  e_rw);
      chk("mem_to_reg_o", bus.mem_to_reg_o, e_m2r);
      chk("pc_src_o",     bus.pc_src_o,     e_pcs);
      chk("alu_src_a_o",  bus.alu_src_a_o,  e_asa);
      chk("alu_src_b_o",  bus.alu_src_b_o,  e_bsel);
      chk("ALUOp_o",      bus.ALUOp_o,      e_aop);
      chk("instr_done_o", bus.instr_done_o, e_done);
      chk("illegal_o",    bus.illegal_o,    e_ill);
      chk("mem_err_o",    bus.mem_err_o,    e_err);
      chk("instr_cnt_o",  bus.instr_cnt_o,  m_cnt);
    end

    if (rst) begin
      m_st = 0; m_cls = 0; m_wait = 0; m_cnt = 16'd0; m_valid = 1'b1;
    end else begin
      if (e_done != 0) m_cnt = m_cnt + 16'd1;
      if (m_st == 1) m_cls = cls_of(bus.opcode_i);
      if ((nx != m_st) || to) m_wait = 0;
      else if (((m_st == 0) || (m_st == 3)) && !rdy) m_wait = m_wait + 1;
      m_st = nx;
    end
  end

  // Samples captured by the directed sequence
  int s_state, s_aluop, s_regw, s_m2r, s_mr, s_pcw, s_pcs, s_done, s_ill, s_err, s_cnt;

  task automatic cyc(input logic r, input logic z, input int exp_st, input string nm);
    bus.mem_ready_i = r;
    bus.zero_i      = z;
    @(negedge clk);
    s_state = bus.state_o;      s_aluop = bus.ALUOp_o;     s_regw = bus.reg_write_o;
    s_m2r   = bus.mem_to_reg_o; s_mr    = bus.mem_read_o;  s_pcw  = bus.pc_write_o;
    s_pcs   = bus.pc_src_o;     s_done  = bus.instr_done_o; s_ill = bus.illegal_o;
    s_err   = bus.mem_err_o;    s_cnt   = bus.instr_cnt_o;
    chk(nm, s_state, exp_st);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int mr_cycles;
  int err_early;
  int burst;
  int pick;

  initial begin
    rst = 1'b1;
    bus.opcode_i    = OP_R;
    bus.zero_i      = 1'b0;
    bus.mem_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Post-reset idle FETCH
    cyc(1'b0, 1'b0, 0, "rst_state");
    chk("rst_mem_read", s_mr, 1);
    chk("rst_cnt", s_cnt, 0);
    chk("rst_done", s_done, 0);

    // Zero-wait R-type: 0,1,2,4
    bus.opcode_i = OP_R;
    cyc(1'b1, 1'b0, 0, "r_fetch");
    cyc(1'b1, 1'b0, 1, "r_decode");
    cyc(1'b1, 1'b0, 2, "r_exec");
    chk("r_exec_aluop", s_aluop, 2);
    cyc(1'b1, 1'b0, 4, "r_wb");
    chk("r_wb_regwrite", s_regw, 1);
    chk("r_wb_done", s_done, 1);

    // LD with three stalled MEM cycles: 8 cycles total
    bus.opcode_i = OP_LD;
    cyc(1'b1, 1'b0, 0, "ld_fetch");
    chk("r_cnt_after", s_cnt, 1);
    cyc(1'b1, 1'b0, 1, "ld_decode");
    cyc(1'b1, 1'b0, 2, "ld_exec");
    mr_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 3, "ld_mem_stall");
      mr_cycles += s_mr;
    end
    cyc(1'b1, 1'b0, 3, "ld_mem_ready");
    mr_cycles += s_mr;
    chk("ld_mem_read_cycles", mr_cycles, 4);
    cyc(1'b1, 1'b0, 4, "ld_wb");
    chk("ld_wb_mem_to_reg", s_m2r, 1);

    // BEQ taken then not taken
    bus.opcode_i = OP_BEQ;
    cyc(1'b1, 1'b1, 0, "beq1_fetch");
    chk("ld_cnt_after", s_cnt, 2);
    cyc(1'b1, 1'b1, 1, "beq1_decode");
    cyc(1'b1, 1'b1, 2, "beq1_exec");
    chk("beq1_pc_write", s_pcw, 1);
    chk("beq1_pc_src", s_pcs, 1);
    chk("beq1_done", s_done, 1);
    cyc(1'b1, 1'b0, 0, "beq2_fetch");
    cyc(1'b1, 1'b0, 1, "beq2_decode");
    cyc(1'b1, 1'b0, 2, "beq2_exec");
    chk("beq2_pc_write", s_pcw, 0);
    chk("beq2_pc_src", s_pcs, 1);

    // Illegal opcode
    bus.opcode_i = 7'b1111111;
    cyc(1'b1, 1'b0, 0, "ill_fetch");
    chk("beq_cnt_after", s_cnt, 4);
    cyc(1'b1, 1'b0, 1, "ill_decode");
    chk("ill_pulse", s_ill, 1);

    // FETCH timeout on the 16th stalled cycle
    err_early = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 0, "to_fetch");
      if (i == 15) chk("to_err_16th", s_err, 1);
      else err_early += s_err;
    end
    chk("to_err_early", err_early, 0);
    cyc(1'b0, 1'b0, 0, "to_after");
    chk("to_after_err", s_err, 0);
    chk("ill_to_cnt_unchanged", s_cnt, 4);

    // Reset during SD MEM, with ready high in the same cycle
    bus.opcode_i = OP_SD;
    cyc(1'b1, 1'b0, 0, "sd_fetch");
    cyc(1'b1, 1'b0, 1, "sd_decode");
    cyc(1'b1, 1'b0, 2, "sd_exec");
    rst = 1'b1;
    cyc(1'b1, 1'b0, 3, "sd_mem_rst");
    chk("sd_rst_no_done", s_done, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 0, "sd_rst_after");
    chk("sd_rst_cnt", s_cnt, 0);

    // Counter wrap: preload 0xFFFF then retire one addi
    force dut.r_instr_cnt = 16'hFFFF;
    load_seq++;
    bus.opcode_i = OP_I;
    cyc(1'b0, 1'b0, 0, "wrap_pre");
    chk("wrap_pre_cnt", s_cnt, 16'hFFFF);
    release dut.r_instr_cnt;
    cyc(1'b1, 1'b0, 0, "i_fetch");
    chk("wrap_hold_cnt", s_cnt, 16'hFFFF);
    cyc(1'b1, 1'b0, 1, "i_decode");
    cyc(1'b1, 1'b0, 2, "i_exec");
    chk("i_exec_aluop", s_aluop, 3);
    cyc(1'b1, 1'b0, 4, "i_wb");
    chk("i_wb_done", s_done, 1);
    cyc(1'b0, 1'b0, 0, "wrap_post");
    chk("wrap_post_cnt", s_cnt, 0);

    // Randomized traffic, checked by the model every cycle
    burst = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (burst > 0) begin
        bus.mem_ready_i = 1'b0;
        burst--;
      end else begin
        if ($urandom_range(0, 59) == 0) burst = $urandom_range(14, 24);
        bus.mem_ready_i = ($urandom_range(0, 3) != 0);
      end
      bus.zero_i = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 5);
      case (pick)
        0: bus.opcode_i = OP_R;
        1: bus.opcode_i = OP_I;
        2: bus.opcode_i = OP_LD;
        3: bus.opcode_i = OP_SD;
        4: bus.opcode_i = OP_BEQ;
        default: bus.opcode_i = 7'($urandom_range(0, 127));
      endcase
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum cycles to wait for mem_ready_i per memory access (range 1..15).
REQ-002 SHALL have port clk_i, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port opcode_i, input, 7: instr[6:0] from the instruction register; valid from DECODE onward.
REQ-005 SHALL have port zero_i, input, 1: ALU zero flag, used in EXEC for beq.
REQ-006 SHALL have port mem_ready_i, input, 1: memory access-complete handshake.
REQ-007 SHALL have outputs pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o, pc_src_o and alu_src_a_o, each 1 bit: datapath strobes and selects.
REQ-008 SHALL have output alu_src_b_o, 2 bits: ALU B operand select; 00 = reg, 01 = constant 4, 10 = immediate.
REQ-009 SHALL have output ALUOp_o, 2 bits: ALU control class; 00 = ld/sd add, 01 = beq sub, 10 = R-type funct decode, 11 = addi.
REQ-010 SHALL have output state_o, 3 bits: current state encoding.
REQ-011 SHALL have outputs instr_done_o, illegal_o and mem_err_o, each 1 bit: one-cycle status pulses.
REQ-012 SHALL have output instr_cnt_o, 16 bits: retired-instruction count.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL go to FETCH on the next edge.
REQ-014 SHALL decode opcode classes: R 0110011, I 0010011, LD 0000011, SD 0100011, BEQ 1100011; all other opcodes are illegal.
REQ-015 FETCH SHALL drive mem_read_o=1, alu_src_a_o=0 (PC), alu_src_b_o=01 and ALUOp_o=00.
REQ-016 In FETCH, mem_ready_i=1 SHALL pulse ir_write_o=1 and pc_write_o=1 combinationally in that cycle and move to DECODE next cycle.
REQ-017 DECODE SHALL last exactly 1 cycle and SHALL latch the opcode class internally.
REQ-018 DECODE SHALL drive alu_src_a_o=0, alu_src_b_o=10 and ALUOp_o=00 to precompute the branch target.
REQ-019 An illegal opcode in DECODE SHALL pulse illegal_o and return to FETCH without incrementing instr_cnt_o.
REQ-020 EXEC SHALL drive alu_src_a_o=1, with alu_src_b_o=00 for R/BEQ and 10 for I/LD/SD.
REQ-021 EXEC SHALL drive ALUOp_o = 10 for R, 11 for I, 00 for LD/SD and 01 for BEQ.
REQ-022 From EXEC, R/I SHALL go to WB, LD/SD SHALL go to MEM, and BEQ SHALL go to FETCH.
REQ-023 BEQ in EXEC SHALL drive pc_src_o=1 and pc_write_o=zero_i, and SHALL pulse instr_done_o.
REQ-024 MEM SHALL drive mem_read_o=1 for LD or mem_write_o=1 for SD, held until mem_ready_i=1.
REQ-025 On mem_ready_i=1 in MEM, LD SHALL go to WB; SD SHALL pulse instr_done_o and go to FETCH.
REQ-026 WB SHALL drive reg_write_o=1 and mem_to_reg_o=1 for LD only, SHALL pulse instr_done_o, and SHALL go to FETCH.
REQ-027 Total latency SHALL be, with zero-wait memory (mem_ready_i=1 the same cycle): R/I 4 cycles, LD 5, SD 4, BEQ 3.
REQ-028 A 4-bit wait counter SHALL clear on entry to FETCH and MEM and increment each cycle mem_ready_i=0 there.
REQ-029 When the wait counter equals WAIT_MAX with mem_ready_i=0, the block SHALL pulse mem_err_o, abort the instruction (no done pulse, no strobes), and go to FETCH.
REQ-030 mem_ready_i SHALL have priority over timeout in the same cycle.
REQ-031 instr_cnt_o SHALL increment by 1 in each cycle instr_done_o=1, wrapping from 0xFFFF to 0x0000.
REQ-032 Every strobe not listed for the current state SHALL be 0, and every select not listed SHALL be 0.

Reset
REQ-033 With rst_i=1 at a clock edge, the next state SHALL be FETCH, with wait counter=0, instr_cnt_o=0 and the latched class cleared.
REQ-034 After reset, all strobes and pulses SHALL be 0 except FETCH's mem_read_o=1, and state_o SHALL be 0.
REQ-035 Reset mid-instruction SHALL abort it with no instr_done_o pulse, and rst_i SHALL override every transition.

Verification
REQ-036 Zero-wait R-type (0110011): states 0,1,2,4 -> ALUOp_o=10 in EXEC, reg_write_o=1 in WB, instr_cnt_o=1.
REQ-037 LD with mem_ready_i delayed 3 cycles in MEM: mem_read_o held 4 cycles, mem_to_reg_o=1 in WB, total 8 cycles.
REQ-038 BEQ with zero_i=1, then with zero_i=0: pc_write_o=1 / 0 in EXEC, pc_src_o=1, both 3 cycles.
REQ-039 Opcode 1111111: illegal_o pulses in DECODE, back to FETCH, instr_cnt_o unchanged.
REQ-040 mem_ready_i held 0 in FETCH with WAIT_MAX=15: mem_err_o pulses on the 16th cycle, state returns to 0.
REQ-041 rst_i during MEM of SD, and instr_cnt_o=0xFFFF plus one addi: state 0 next cycle with no done pulse; count wraps to 0x0000.
